// File: rtl/master_bus_port.sv
// Bus master endpoint: latches one command, requests the bus, shifts the frame out and collects ack/read data.
// Optional MASTER_TIMEOUT_EN adds a response-wait timeout that aborts the transaction with an error pulse.
module master_bus_port #(
  parameter int SLV_W   = 2,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  rw,
  input  logic [SLV_W-1:0]      slave_id,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [DATA_W-1:0]     rdata,
  output logic                  bus_req,
  input  logic                  bus_grant,
  input  logic [2**SLV_W-1:0]   slave_busy,
  output logic                  bus_dout,
  output logic                  bus_dout_valid,
  input  logic                  bus_din,
  input  logic                  bus_din_valid,
  input  logic                  bus_ack
);

  localparam int FW     = SLV_W + 1 + ADDR_W + DATA_W;
  localparam int RD_LEN = SLV_W + 1 + ADDR_W;
  localparam int CW     = $clog2(FW);
  localparam logic [CW-1:0] WR_LAST = CW'(FW - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(RD_LEN - 1);
  localparam logic [CW-1:0] RX_LAST = CW'(DATA_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_SEND, S_WAIT, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_rw;
  logic [SLV_W-1:0]    r_sid;
  logic [FW-1:0]       r_frame;
  logic [CW-1:0]       r_cnt;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_error;
  logic                w_abort;
  logic                w_tmo;

`ifdef MASTER_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [TW-1:0] r_tcnt;

  // Counts WAIT_RESP cycles since the last sign of life from the slave.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt <= '0;
    end else if (r_state != S_WAIT || bus_din_valid || bus_ack) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  assign w_tmo = (r_state == S_WAIT) && !bus_din_valid && !bus_ack &&
                 (r_tcnt == TW'(TIMEOUT - 1));
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next         = r_state;
    w_abort        = 1'b0;
    busy           = (r_state != S_IDLE);
    bus_req        = (r_state == S_REQ) || (r_state == S_SEND) || (r_state == S_WAIT);
    done           = (r_state == S_DONE);
    error          = r_error;
    rdata          = r_rdata;
    bus_dout_valid = (r_state == S_SEND);
    bus_dout       = (r_state == S_SEND) && r_frame[FW-1];
    case (r_state)
      S_IDLE: if (start) w_next = S_REQ;
      S_REQ:  if (bus_grant && !slave_busy[r_sid]) w_next = S_SEND;
      S_SEND: begin
        if (!bus_grant) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else if (r_cnt == (r_rw ? WR_LAST : RD_LAST)) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!bus_grant || w_tmo) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else if (r_rw ? bus_ack : (bus_din_valid && r_cnt == RX_LAST)) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // r_cnt counts frame bits in SEND and received data bits in WAIT_RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rw    <= 1'b0;
      r_sid   <= '0;
      r_frame <= '0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_rdata <= '0;
      r_error <= 1'b0;
    end else begin
      r_error <= w_abort;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rw    <= rw;
            r_sid   <= slave_id;
            r_frame <= {slave_id, rw, addr, wdata};
            r_cnt   <= '0;
          end
        end
        S_SEND: begin
          r_frame <= {r_frame[FW-2:0], 1'b0};
          r_cnt   <= (w_next == S_WAIT) ? '0 : r_cnt + 1'b1;
        end
        S_WAIT: begin
          if (!r_rw && bus_din_valid) begin
            r_shift <= {r_shift[DATA_W-2:0], bus_din};
            r_cnt   <= r_cnt + 1'b1;
            if (w_next == S_DONE) r_rdata <= {r_shift[DATA_W-2:0], bus_din};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_master_bus_port.sv
// Randomized scoreboard bench for master_bus_port: the driver queues expected frame bits and
// completion events from a transaction-level model; a negedge monitor pops and compares them.
module tb_master_bus_port;

`ifdef MASTER_TIMEOUT_EN
  localparam int TMO    = 20;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 255;
  localparam bit TMO_EN = 1'b0;
`endif

  typedef struct {
    logic       err;
    logic [7:0] rd;
  } evt_t;

  logic        clk, rst, start, rw;
  logic [1:0]  slave_id;
  logic [11:0] addr;
  logic [7:0]  wdata;
  logic        busy, done, error;
  logic [7:0]  rdata;
  logic        bus_req, bus_grant;
  logic [3:0]  slave_busy;
  logic        bus_dout, bus_dout_valid, bus_din, bus_din_valid, bus_ack;

  master_bus_port #(.SLV_W(2), .ADDR_W(12), .DATA_W(8), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .slave_id(slave_id),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .error(error),
    .rdata(rdata), .bus_req(bus_req), .bus_grant(bus_grant),
    .slave_busy(slave_busy), .bus_dout(bus_dout), .bus_dout_valid(bus_dout_valid),
    .bus_din(bus_din), .bus_din_valid(bus_din_valid), .bus_ack(bus_ack)
  );

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic       q_bits[$];
  evt_t       q_evt[$];
  logic [7:0] exp_rdata = 8'h00;
  logic       m_bit;
  evt_t       m_evt;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=present required=absent", name);
  endtask

  function automatic logic [3:0] busy_vec(input logic [1:0] sid, input logic b);
    logic [3:0] v;
    v = 4'($urandom);
    v[sid] = b;
    return v;
  endfunction

  // Monitor: consumes expectations whenever the DUT presents a frame bit or a completion.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_dout_valid) begin
        if (q_bits.size() == 0) note_fail("unexpected_bit");
        else begin
          m_bit = q_bits.pop_front();
          check("frame_bit", 32'(bus_dout), 32'(m_bit));
        end
      end
      if (done || error) begin
        check("done_error_excl", 32'(done && error), 32'd0);
        if (q_evt.size() == 0) note_fail("unexpected_event");
        else begin
          m_evt = q_evt.pop_front();
          check("evt_kind", 32'(error), 32'(m_evt.err));
          check("evt_rdata", 32'(rdata), 32'(m_evt.rd));
        end
      end
    end
  end

  // abort_kind: 0 normal, 1 grant drop at abort_bit, 2 reset at abort_bit, 3 write with withheld ack.
  // gap < 0 picks random response gaps of 0..3 cycles.
  task automatic run_txn(input logic t_rw, input logic [1:0] t_sid, input logic [11:0] t_addr,
                         input logic [7:0] t_wd, input logic [7:0] t_rd, input int gwait,
                         input int sbusy, input int abort_kind, input int abort_bit, input int gap);
    logic [22:0] frame;
    int len, tgt, hold, t0, seen, it, exp_lat, g, resp;
    evt_t e;
    frame = {t_sid, t_rw, t_addr, t_wd};
    len   = t_rw ? 23 : 15;
    tgt   = (abort_kind == 1 || abort_kind == 2) ? abort_bit + 1 : len;
    for (int i = 0; i < tgt; i++) q_bits.push_back(frame[22-i]);
    hold = 1;
    if (gwait > hold) hold = gwait;
    if (sbusy > hold) hold = sbusy;
    if (abort_kind == 1 || (abort_kind == 3 && TMO_EN)) begin
      e.err = 1'b1; e.rd = exp_rdata; q_evt.push_back(e);
    end else if (abort_kind != 2) begin
      if (!t_rw) exp_rdata = t_rd;
      e.err = 1'b0; e.rd = exp_rdata; q_evt.push_back(e);
    end

    @(negedge clk);
    check("pulse_one_cycle", 32'({done, error}), 32'd0);
    start = 1'b1; rw = t_rw; slave_id = t_sid; addr = t_addr; wdata = t_wd;
    bus_grant = (gwait == 0); slave_busy = busy_vec(t_sid, sbusy > 0);
    t0 = cyc;
    for (int j = 1; j <= hold; j++) begin
      @(negedge clk);
      if (j == 1) check("req_after_start", 32'({bus_req, busy}), 32'd3);
      check("hold_no_frame", 32'({bus_req, bus_dout_valid}), 32'd2);
      start = 1'($urandom); rw = 1'($urandom); slave_id = 2'($urandom);
      addr = 12'($urandom); wdata = 8'($urandom);
      bus_grant = (j >= gwait); slave_busy = busy_vec(t_sid, j < sbusy);
    end

    seen = 0; it = 0;
    while (seen < tgt && it < 40) begin
      @(negedge clk);
      it++; start = 1'b0;
      if (bus_dout_valid) seen++;
      bus_ack = 1'($urandom); bus_din_valid = 1'($urandom); bus_din = 1'($urandom);
    end
    check("frame_length", 32'(seen), 32'(tgt));

    if (abort_kind == 1) begin
      bus_grant = 1'b0;
      @(negedge clk);
      bus_ack = 1'b0; bus_din_valid = 1'b0;
      check("drop_to_idle", 32'({error, bus_req, busy, bus_dout_valid}), 32'h8);
      return;
    end
    if (abort_kind == 2) begin
      #1 rst = 1'b1;
      #1 check("rst_clears", 32'({busy, done, error, bus_req, bus_dout, bus_dout_valid, rdata}), 32'd0);
      q_bits.delete();
      exp_rdata = 8'h00;
      @(negedge clk);
      rst = 1'b0; bus_ack = 1'b0; bus_din_valid = 1'b0;
      return;
    end

    if (t_rw) begin
      if (abort_kind == 3 && TMO_EN) begin
        for (int w = 0; w < TMO; w++) begin
          @(negedge clk); bus_ack = 1'b0; bus_din_valid = 1'b0;
        end
        @(negedge clk);
        check("timeout_error", 32'({error, busy}), 32'd2);
        return;
      end
      g = (gap < 0) ? $urandom_range(0, 3) : gap;
      for (int k = 0; k < g; k++) begin
        @(negedge clk); bus_ack = 1'b0; bus_din_valid = 1'b0;
      end
      if (abort_kind == 3) check("no_timeout_busy", 32'({busy, bus_req, error}), 32'd6);
      @(negedge clk); bus_ack = 1'b1; bus_din_valid = 1'b0;
      exp_lat = hold + len + g + 1 + 1;
    end else begin
      resp = 0;
      for (int b = 0; b < 8; b++) begin
        g = (gap < 0) ? $urandom_range(0, 3) : gap;
        for (int k = 0; k < g; k++) begin
          @(negedge clk); bus_ack = 1'b0; bus_din_valid = 1'b0; bus_din = 1'($urandom);
        end
        @(negedge clk); bus_ack = 1'b0; bus_din_valid = 1'b1; bus_din = t_rd[7-b];
        resp += g + 1;
      end
      exp_lat = hold + len + resp + 1;
    end
    @(negedge clk);
    bus_ack = 1'b0; bus_din_valid = 1'b0;
    check("done_pulse", 32'({done, bus_req}), 32'd2);
    check("latency", 32'(cyc - t0), 32'(exp_lat));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rw = 1'b0; slave_id = '0; addr = '0; wdata = '0;
    bus_grant = 1'b0; slave_busy = '0; bus_din = 1'b0; bus_din_valid = 1'b0; bus_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({busy, done, error, bus_req, bus_dout, bus_dout_valid}), 32'd0);
    check("reset_rdata", 32'(rdata), 32'd0);
    rst = 1'b0;

    // Write slave 2 / 0xABC / 0x5A with immediate grant and ack: done in cycle 26.
    run_txn(1'b1, 2'd2, 12'hABC, 8'h5A, 8'h00, 0, 0, 0, 0, 0);
    // Read slave 1 / 0x001 returning 0xC3 with one-cycle gaps.
    run_txn(1'b0, 2'd1, 12'h001, 8'h00, 8'hC3, 0, 0, 0, 0, 1);
    // Target slave 3 busy for 10 cycles while grant is high.
    run_txn(1'b1, 2'd3, 12'h3F0, 8'hA5, 8'h00, 0, 11, 0, 0, 0);
    // Grant drops on frame bit 5: error, rdata kept.
    run_txn(1'b0, 2'd0, 12'h555, 8'h00, 8'h77, 0, 0, 1, 5, 0);
    // Withheld ack: timeout with the feature, otherwise still busy after 300 cycles.
    run_txn(1'b1, 2'd1, 12'h123, 8'h3C, 8'h00, 0, 0, 3, 0, 300);
    // Reset mid-frame, then a clean read.
    run_txn(1'b0, 2'd2, 12'h0F0, 8'h00, 8'h99, 0, 0, 2, 4, 0);
    run_txn(1'b0, 2'd3, 12'hFED, 8'h00, 8'h6E, 2, 1, 0, 0, -1);

    for (int n = 0; n < 25; n++) begin
      logic r_rw_t;
      int ab, abit;
      r_rw_t = 1'($urandom);
      ab     = ($urandom_range(0, 7) == 0) ? 1 : 0;
      abit   = $urandom_range(0, r_rw_t ? 22 : 14);
      run_txn(r_rw_t, 2'($urandom), 12'($urandom), 8'($urandom), 8'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), ab, abit, -1);
    end

    repeat (3) @(negedge clk);
    check("bits_drained", 32'(q_bits.size()), 32'd0);
    check("events_drained", 32'(q_evt.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
